// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, instruction-class and condition-code definitions for the CPU sequencer
package cpu_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_e;
    typedef enum logic [2:0] {
        CL_DP, CL_DP_S, CL_LDR, CL_STR, CL_B, CL_BL, CL_NOP, CL_UNDEF
    } class_e;
    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_e;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: ARM condition-field evaluation against the NZCV flags
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond_field,
    input  logic [3:0] cpsr,
    output logic       pass
);
    logic n, z, c, v;
    assign n = cpsr[N_BIT];
    assign z = cpsr[Z_BIT];
    assign c = cpsr[C_BIT];
    assign v = cpsr[V_BIT];
    always_comb begin
        case (cond_e'(cond_field))
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = n == v;
            CC_LT: pass = n != v;
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: stall-aware multi-cycle control FSM for the single-issue CPU datapath
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       instr_class,
    input  logic [3:0]       cond_field,
    input  logic [3:0]       cpsr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             instruction_en,
    output logic             read_en,
    output logic             alu_en,
    output logic             cpsr_we,
    output logic             write_en,
    output logic             lr_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             retired,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    state_e           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass, tmo;
    class_e           cls;

    cond_check u_cond (.cond_field(cond_field), .cpsr(cpsr), .pass(pass));

    assign cls            = class_e'(instr_class);
    assign tmo            = tmo_q == TW'(MEM_TIMEOUT);
    assign imem_req       = state_q == S_FETCH;
    assign instruction_en = imem_req && imem_ack;
    assign read_en        = state_q == S_READ;
    assign alu_en         = state_q == S_EXEC;
    assign cpsr_we        = alu_en && cls == CL_DP_S;
    assign lr_we          = alu_en && cls == CL_BL;
    assign pc_sel         = alu_en && cls inside {CL_B, CL_BL};
    assign dmem_req       = state_q == S_MEM;
    assign dmem_we        = dmem_req && cls == CL_STR;
    assign write_en       = state_q == S_WB;
    assign fault          = state_q == S_FAULT;
    assign retired        = (state_q == S_DECODE && !pass)
                          || (alu_en && cls inside {CL_B, CL_BL, CL_NOP})
                          || (dmem_we && dmem_ack) || write_en;
    assign pc_we          = retired;
    assign state          = state_q;
    assign instr_count    = cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = imem_ack ? S_DECODE : tmo ? S_FAULT : S_FETCH;
            S_DECODE: state_d = cls == CL_UNDEF ? S_FAULT : S_READ;
            S_READ:   state_d = S_EXEC;
            S_EXEC:   state_d = cls inside {CL_LDR, CL_STR} ? S_MEM
                              : cls inside {CL_DP, CL_DP_S} ? S_WB : S_FAULT;
            S_MEM:    state_d = dmem_ack ? S_WB : tmo ? S_FAULT : S_MEM;
            default:  state_d = state_q;
        endcase
        if (retired) state_d = run ? S_FETCH : S_IDLE;
        // any state change restarts the wait counter, so it is zero on entry to FETCH/MEM
        tmo_d = state_d == state_q ? tmo_q + 1'b1 : '0;
        cnt_d = retired ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench; expected retire records are queued at issue and checked at each retired pulse
module tb_cpu_sequencer;
    localparam logic [2:0] DP = 3'd0, DPS = 3'd1, LDR = 3'd2, STR = 3'd3;
    localparam logic [2:0] BR = 3'd4, BL = 3'd5, NOP = 3'd6, UND = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1, run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [2:0] instr_class = '0;
    logic [3:0] cond_field = 4'hE, cpsr = '0;
    logic imem_req, dmem_req, dmem_we, instruction_en, read_en, alu_en, cpsr_we;
    logic write_en, lr_we, pc_we, pc_sel, retired, fault;
    logic [2:0] state;
    logic [15:0] instr_count;
    logic [12:0] outs;

    cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .instr_class(instr_class),
        .cond_field(cond_field), .cpsr(cpsr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .instruction_en(instruction_en), .read_en(read_en), .alu_en(alu_en),
        .cpsr_we(cpsr_we), .write_en(write_en), .lr_we(lr_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .retired(retired), .fault(fault), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign outs = {imem_req, dmem_req, dmem_we, instruction_en, read_en, alu_en, cpsr_we,
                   write_en, lr_we, pc_we, pc_sel, retired, fault};

    typedef struct {int lat; bit pc_sel; bit lr; bit wen;} exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0, cyc = 0, start = 0, fw = 0, dw = 0;
    int imem_dly = 0, dmem_dly = 0;
    int c_ireq = 0, c_dreq = 0, c_dwe = 0, c_wen = 0, c_cwe = 0, c_lr = 0;
    bit ack_all = 1'b0;
    logic [2:0] prev_state = '0, s_state = '0;
    logic [12:0] s_outs = '0;
    logic [15:0] s_cnt = '0, exp_cnt = '0;
    logic s_ret = 1'b0, s_wen = 1'b0, s_fault = 1'b0;

    function automatic bit cpass(input logic [3:0] cd, input logic [3:0] f);
        bit n, z, c, v, b;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cd[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c && !z;
            3'd5: b = n == v;
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return cd[0] ? !b : b;
    endfunction

    function automatic exp_t model(input logic [2:0] c, input logic [3:0] cd, input logic [3:0] f,
                                   input int idly, input int ddly);
        exp_t e;
        e.lat = idly + 4; e.pc_sel = 1'b0; e.lr = 1'b0; e.wen = 1'b0;
        if (!cpass(cd, f)) e.lat = idly + 2;
        else if (c == DP || c == DPS) begin e.lat = idly + 5; e.wen = 1'b1; end
        else if (c == LDR) begin e.lat = idly + ddly + 6; e.wen = 1'b1; end
        else if (c == STR) e.lat = idly + ddly + 5;
        else if (c == BR || c == BL) begin e.pc_sel = 1'b1; e.lr = c == BL; end
        return e;
    endfunction

    task automatic clr();
        c_ireq = 0; c_dreq = 0; c_dwe = 0; c_wen = 0; c_cwe = 0; c_lr = 0;
    endtask

    // one clock: drive acks for this cycle, sample at negedge, consume scoreboard on retire
    task automatic step();
        exp_t e;
        int lat;
        imem_ack = ack_all || (state == 3'd1 && fw >= imem_dly);
        dmem_ack = ack_all || (state == 3'd5 && dw >= dmem_dly);
        @(negedge clk);
        cyc++;
        s_outs = outs; s_state = state; s_cnt = instr_count;
        s_ret = retired; s_wen = write_en; s_fault = fault;
        if (state == 3'd1 && prev_state != 3'd1) start = cyc;
        prev_state = state;
        fw = state == 3'd1 ? fw + 1 : 0;
        dw = state == 3'd5 ? dw + 1 : 0;
        c_ireq += int'(imem_req); c_dreq += int'(dmem_req); c_dwe += int'(dmem_we);
        c_wen += int'(write_en); c_cwe += int'(cpsr_we); c_lr += int'(lr_we);
        if (retired) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire got retired=1 exp no retire (state %0d)", state);
            end else begin
                e = sb.pop_front();
                lat = cyc - start + 1;
                if (lat != e.lat) begin
                    errors++;
                    $display("FAIL retire_latency got %0d exp %0d", lat, e.lat);
                end
                checks++;
                if ({pc_we, pc_sel, lr_we, write_en} !== {1'b1, e.pc_sel, e.lr, e.wen}) begin
                    errors++;
                    $display("FAIL retire_strobes got pc_we,pc_sel,lr_we,write_en=%b exp %b",
                             {pc_we, pc_sel, lr_we, write_en}, {1'b1, e.pc_sel, e.lr, e.wen});
                end
                checks++;
                if (instr_count !== exp_cnt) begin
                    errors++;
                    $display("FAIL instr_count got %h exp %h", instr_count, exp_cnt);
                end
                exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [3:0] cd, input logic [3:0] f,
                         input int idly, input int ddly, input bit drop = 1'b0);
        bit got = 1'b0;
        sb.push_back(model(c, cd, f, idly, ddly));
        instr_class = c; cond_field = cd; cpsr = f;
        imem_dly = idly; dmem_dly = ddly; run = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            step();
            got = s_ret;
            if (drop) run = 1'b0;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL retire_wait got no retire exp retire class %0d cond %h", c, cd);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        run = 1'b1;
        step();
        step();
        checks++;
        if (s_state !== 3'd0 || s_outs !== '0 || s_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state got state %0d outs %b cnt %h exp 0", s_state, s_outs, s_cnt);
        end
        rst = 1'b0; run = 1'b0; ack_all = 1'b1;
        repeat (3) step();
        ack_all = 1'b0;
        checks++;
        if (s_state !== 3'd0 || s_outs !== '0) begin
            errors++;
            $display("FAIL idle_ack_ignored got state %0d outs %b exp 0", s_state, s_outs);
        end
    endtask

    task automatic test_dp();
        logic [2:0] st [5];
        logic [2:0] want [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        sb.push_back(model(DP, 4'hE, 4'h0, 0, 0));
        instr_class = DP; cond_field = 4'hE; imem_dly = 0; run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); st[i] = s_state; end
        checks++;
        if (st != want) begin
            errors++;
            $display("FAIL dp_sequence got %0d %0d %0d %0d %0d exp 1 2 3 4 6",
                     st[0], st[1], st[2], st[3], st[4]);
        end
        checks++;
        if (!(s_wen && s_ret)) begin
            errors++;
            $display("FAIL dp_wb_cycle got write_en %b retired %b exp 1 1", s_wen, s_ret);
        end
        step();
        checks++;
        if (s_state !== 3'd0 || s_cnt !== 16'd1) begin
            errors++;
            $display("FAIL dp_after got state %0d cnt %0d exp state 0 cnt 1", s_state, s_cnt);
        end
    endtask

    task automatic test_cond_bl();
        clr();
        issue(BL, 4'h0, 4'b0100, 0, 0);
        checks++;
        if (c_lr != 1) begin errors++; $display("FAIL bl_lr_we got %0d exp 1", c_lr); end
        clr();
        issue(BL, 4'h0, 4'b0000, 0, 0);
        checks++;
        if (c_lr != 0) begin errors++; $display("FAIL bl_condfail_lr_we got %0d exp 0", c_lr); end
        issue(BR, 4'hE, 4'h0, 0, 0);
        for (int cd = 0; cd < 16; cd++)
            for (int f = 0; f < 16; f += 3)
                issue(NOP, 4'(cd), 4'(f), 0, 0);
    endtask

    task automatic test_mem();
        clr();
        issue(LDR, 4'hE, 4'h0, 0, 3);
        checks++;
        if (c_dreq != 4 || c_dwe != 0 || c_wen != 1) begin
            errors++;
            $display("FAIL ldr_mem got dreq %0d dwe %0d wen %0d exp 4 0 1", c_dreq, c_dwe, c_wen);
        end
        clr();
        issue(STR, 4'hE, 4'h0, 1, 2);
        checks++;
        if (c_dreq != 3 || c_dwe != 3 || c_wen != 0) begin
            errors++;
            $display("FAIL str_mem got dreq %0d dwe %0d wen %0d exp 3 3 0", c_dreq, c_dwe, c_wen);
        end
        clr();
        issue(DPS, 4'hE, 4'h0, 0, 0);
        issue(DP, 4'hE, 4'h0, 0, 0);
        checks++;
        if (c_cwe != 1) begin errors++; $display("FAIL cpsr_we got %0d exp 1", c_cwe); end
        issue(LDR, 4'hE, 4'h0, 0, 15);
    endtask

    task automatic test_timeout();
        bit got = 1'b0;
        instr_class = DP; cond_field = 4'hE; imem_dly = 99; run = 1'b1;
        clr();
        for (int i = 0; i < 40 && !got; i++) begin step(); got = s_fault; end
        checks++;
        if (!got || c_ireq != 16) begin
            errors++;
            $display("FAIL fetch_timeout got fault %b req_cycles %0d exp 1 16", got, c_ireq);
        end
        checks++;
        if (s_state !== 3'd7 || s_outs !== 13'h1) begin
            errors++;
            $display("FAIL fault_outputs got state %0d outs %b exp 7 %b", s_state, s_outs, 13'h1);
        end
        ack_all = 1'b1;
        repeat (3) step();
        ack_all = 1'b0;
        checks++;
        if (s_state !== 3'd7 || s_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky got state %0d fault %b exp 7 1", s_state, s_fault);
        end
        do_reset();
        step();
        checks++;
        if (s_state !== 3'd0 || s_outs !== '0) begin
            errors++;
            $display("FAIL fault_clear got state %0d outs %b exp 0", s_state, s_outs);
        end
        issue(DP, 4'hE, 4'h0, 15, 0);
        instr_class = LDR; imem_dly = 0; dmem_dly = 99; got = 1'b0;
        clr();
        for (int i = 0; i < 40 && !got; i++) begin step(); got = s_fault; end
        checks++;
        if (!got || c_dreq != 16) begin
            errors++;
            $display("FAIL mem_timeout got fault %b req_cycles %0d exp 1 16", got, c_dreq);
        end
        do_reset();
        instr_class = UND; got = 1'b0;
        clr();
        for (int i = 0; i < 10 && !got; i++) begin step(); got = s_fault; end
        checks++;
        if (!got || c_ireq != 1) begin
            errors++;
            $display("FAIL undef_fault got fault %b fetches %0d exp 1 1", got, c_ireq);
        end
        do_reset();
        issue(UND, 4'hF, 4'h0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        issue(NOP, 4'hE, 4'h0, 0, 0);
        instr_class = DP; cond_field = 4'hE; imem_dly = 2; run = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin step(); got = s_state == 3'd3; end
        rst = 1'b1;
        step();
        checks++;
        if (!got || s_state !== 3'd4) begin
            errors++;
            $display("FAIL reach_exec got state %0d exp 4", s_state);
        end
        rst = 1'b0; run = 1'b0;
        sb.delete();
        exp_cnt = '0;
        step();
        checks++;
        if (s_state !== 3'd0 || s_outs !== '0 || s_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid got state %0d outs %b cnt %h exp 0", s_state, s_outs, s_cnt);
        end
    endtask

    task automatic test_wrap();
        run = 1'b0;
        for (int i = 0; i < 10 && s_state != 3'd0; i++) step();
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        issue(NOP, 4'hE, 4'h0, 0, 0, 1'b1);
        step();
        checks++;
        if (s_state !== 3'd0 || s_cnt !== 16'h0) begin
            errors++;
            $display("FAIL wrap_idle got state %0d cnt %h exp 0 0000", s_state, s_cnt);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_dp();
        test_cond_bl();
        test_mem();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the single-issue CPU datapath.
- Sequences fetch, decode, register read, ALU execute, data memory and writeback, and handshakes with instruction and data memory.
- Evaluates ARM condition codes and drives the PC, CPSR, LR and register-file write strobes.
- Replaces the free-running 4-phase cycle counter with a stall-aware, class-dependent sequence.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles for imem_ack/dmem_ack before entering FAULT.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  allow new instructions to start.
- instr_class  in  3  decoder class: 0 DP, 1 DP_S (sets flags), 2 LDR, 3 STR, 4 B, 5 BL, 6 NOP, 7 UNDEF.
- cond_field  in  4  instruction condition field.
- cpsr  in  4  flags: [3] N, [2] Z, [1] C, [0] V.
- imem_ack  in  1  instruction word valid.
- dmem_ack  in  1  data access complete.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data request.
- dmem_we  out  1  data write (STR).
- instruction_en  out  1  latch the decoder.
- read_en  out  1  register-file read.
- alu_en  out  1  ALU operand/result capture.
- cpsr_we  out  1  CPSR update.
- write_en  out  1  register-file write of Rd.
- lr_we  out  1  write PC+4 to R14.
- pc_we  out  1  PC update.
- pc_sel  out  1  0 selects PC+4, 1 selects the branch target.
- retired  out  1  one-cycle pulse at instruction completion.
- fault  out  1  sticky fault.
- state  out  3  current state (debug port).
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - rst is sampled on clk and dominates all other inputs.
  - Next state is IDLE; instr_count=0; timeout counter=0.
  - All outputs are 0, including fault.
  - Reset mid-operation drops any outstanding request the following cycle.
- State encoding: IDLE 0, FETCH 1, DECODE 2, READ 3, EXEC 4, MEM 5, WB 6, FAULT 7.
- All strobe outputs are Moore or Mealy decodes of the current state and are 0 outside the cases listed below.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1 is held until imem_ack.
  - On the ack cycle: instruction_en=1, then go to DECODE.
- DECODE (one cycle):
  - Condition fails: pc_we=1, pc_sel=0, retired=1.
  - UNDEF (with condition pass): go to FAULT.
  - Otherwise: go to READ.
- READ: read_en=1 for one cycle, then go to EXEC.
- EXEC: alu_en=1, then by class:
  - DP: go to WB.
  - DP_S: cpsr_we=1, then go to WB.
  - LDR/STR: go to MEM.
  - B: pc_we=1, pc_sel=1, retired=1.
  - BL: as B, plus lr_we=1 in the same cycle.
  - NOP: pc_we=1, pc_sel=0, retired=1.
- MEM:
  - dmem_req=1 is held until dmem_ack; dmem_we=1 for STR.
  - On ack for STR: pc_we=1, pc_sel=0, retired=1.
  - On ack for LDR: go to WB.
- WB: write_en=1, pc_we=1, pc_sel=0, retired=1.
- After any retire: go to FETCH if run=1, else IDLE.
  - Deasserting run never aborts an in-flight instruction.
- FAULT:
  - fault=1; all strobes and requests are 0.
  - Exits only via rst.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each wait cycle without ack.
  - Counter == MEM_TIMEOUT with ack still low goes to FAULT.
  - An ack arriving in the same cycle wins over the timeout.
- Acks received while the matching req=0 are ignored.
- Minimum latency in cycles, with acks arriving in the request cycle:

| Class | Cycles |
|---|---|
| DP / DP_S | 5 |
| B / BL / NOP | 4 |
| STR | 5 |
| LDR | 6 |
| condition-fail | 2 |

- Condition codes:

| Code | Name | Pass when |
|---|---|---|
| 0 | EQ | Z |
| 1 | NE | !Z |
| 2 | CS | C |
| 3 | CC | !C |
| 4 | MI | N |
| 5 | PL | !N |
| 6 | VS | V |
| 7 | VC | !V |
| 8 | HI | C & !Z |
| 9 | LS | !C \| Z |
| A | GE | N == V |
| B | LT | N != V |
| C | GT | !Z & (N == V) |
| D | LE | Z \| (N != V) |
| E | AL | always |
| F | NV | never |

- cpsr is sampled in DECODE.
- instr_count increments on every retired pulse, including condition-failed instructions, and wraps from all-ones to 0.

Decomposition:
- Package cpu_pkg holds:
  - the state enum;
  - instr_class codes;
  - condition-code constants;
  - CPSR bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- One combinational sub-module, cond_check, with inputs cond_field and cpsr and output pass.

Test Plan:
1. rst=1 for 2 cycles, run=1, DP instruction, cond=E, acks immediate -> states 1,2,3,4,6; write_en and retired high in cycle 5; instr_count=1.
2. BL with cond=0 (EQ) and cpsr=4'b0100 -> lr_we, pc_we and pc_sel all 1 in the EXEC cycle; 4-cycle retire. Repeat with cpsr=0 -> retire in DECODE with pc_sel=0 and no lr_we.
3. LDR with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then WB write_en=1; STR -> dmem_we=1 and retire on the ack cycle.
4. FETCH with imem_ack never asserted, MEM_TIMEOUT=15 -> FAULT after 16 request cycles, fault=1, imem_req=0; rst clears fault.
5. DP with imem_ack low, then rst asserted in EXEC -> next cycle state=0, all strobes 0, instr_count=0.
6. Force instr_count=16'hFFFF via 65535 NOPs (or a preloaded hierarchical force), one more NOP -> wraps to 0; run dropped mid-NOP -> the NOP completes, then IDLE.
